// File: rtl/if_stage_pkg.sv
// Shared widths and constants for the instruction fetch stage.
package if_stage_pkg;

  localparam int              CPU_WIDTH   = 32;
  localparam int              PC_W        = 64;
  localparam logic [PC_W-1:0] RESET_PC    = 64'h0000_0000_8000_0000;
  localparam int              INST_BYTES  = 4;
  localparam logic [31:0]     NOP         = 32'h0000_0013;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the decode handshake.
interface if_stage_if #(
  parameter int PC_W   = if_stage_pkg::PC_W,
  parameter int INST_W = if_stage_pkg::CPU_WIDTH
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/if_stage_fifo.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally (zero when empty).
module if_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_stage.sv
// RV64 instruction fetch: credit-limited in-order fetch, flush/restart on redirect.
// Optional IF_MISALIGN_CHK_EN adds a sticky fetch_misalign trap for misaligned redirect targets.
module if_stage #(
  parameter int              PC_W      = if_stage_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter int              INST_W    = if_stage_pkg::CPU_WIDTH,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  if_stage_if.master      bus
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            fetch_misalign
`endif
);

  import if_stage_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [PC_W-1:0]        pc_reg, pc_next, target_pc, head_addr;
  logic [CW-1:0]          drop_cnt_reg, drop_cnt_next, inflight, buf_count;
  logic [CW:0]            credit_used;
  logic [INST_W+PC_W-1:0] head_entry;
  logic                   req_fire, rsp_ok, rsp_keep, inst_pop, halt;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_reg <= 1'b1;
    end
  end

  assign target_pc      = redirect_pc;
  assign halt           = misalign_reg;
  assign fetch_misalign = misalign_reg;
`else
  assign target_pc = redirect_pc & ~PC_W'(3);
  assign halt      = 1'b0;
`endif

  assign inst_pop = bus.inst_valid && bus.inst_ready && !redirect_valid;

  // A slot freed by this cycle's decode pop is reusable at once, sustaining one fetch per cycle.
  assign credit_used = {1'b0, inflight} + {1'b0, buf_count} - {{CW{1'b0}}, inst_pop};

  assign bus.imem_req_valid = rst_n && !redirect_valid && !halt &&
                              (credit_used < (CW+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc_reg;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses with nothing outstanding are protocol errors and never touch the queues.
  assign rsp_ok   = bus.imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_ok && (drop_cnt_reg == '0) && !redirect_valid;

  always_comb begin
    pc_next       = pc_reg;
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid) begin
      pc_next       = target_pc;
      drop_cnt_next = inflight - CW'(rsp_ok);
    end else begin
      if (req_fire) pc_next = pc_reg + PC_W'(INST_BYTES);
      if (rsp_ok && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      drop_cnt_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Addresses of outstanding requests; its occupancy is the in-flight count.
  if_fifo #(.WIDTH(PC_W), .DEPTH(BUF_DEPTH)) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_ok),
    .flush     (1'b0),
    .head      (head_addr),
    .count     (inflight)
  );

  if_fifo #(.WIDTH(INST_W + PC_W), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({bus.imem_rsp_data, head_addr}),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (buf_count)
  );

  assign bus.inst_valid = (buf_count != '0);
  assign bus.inst       = head_entry[PC_W +: INST_W];
  assign bus.inst_pc    = head_entry[PC_W-1:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, fixed-latency instruction memory model.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  typedef struct { int cyc; logic [63:0] addr; } req_t;
  typedef struct { int cyc; logic [63:0] pc; logic [31:0] data; } pop_t;
  typedef struct { int due; logic [31:0] data; } mem_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  req_t req_log[$];
  pop_t pop_log[$];
  mem_t mq[$];
  int   cyc, lat;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(BASE), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[31:0] ^ NOP;
  endfunction

  task automatic drive_mem();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mq[0].data;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic finish_cycle();
    req_t r;
    pop_t p;
    mem_t m;
    if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      r.cyc = cyc; r.addr = bus.imem_req_addr; req_log.push_back(r);
      m.due = cyc + lat; m.data = mem_word(bus.imem_req_addr); mq.push_back(m);
    end
    if (bus.inst_valid && bus.inst_ready) begin
      p.cyc = cyc; p.pc = bus.inst_pc; p.data = bus.inst; pop_log.push_back(p);
      $display("cyc %0d: decode takes pc=%h inst=%h", cyc, bus.inst_pc, bus.inst);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic cycle();
    drive_mem();
    #1;
    finish_cycle();
  endtask

  task automatic do_reset(int latency);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    mq.delete(); lat = latency;
    repeat (2) @(negedge clk);
    req_log.delete(); pop_log.delete();
    rst_n = 1'b1; cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1);
    repeat (3) cycle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", bus.inst); end
    checks++; if (bus.inst_pc !== 64'h0) begin errors++; $display("FAIL rst_inst_pc: got %h want 0", bus.inst_pc); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== BASE) begin errors++; $display("FAIL rst_req_addr: got %h want %h", bus.imem_req_addr, BASE); end
`ifdef IF_MISALIGN_CHK_EN
    checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", fetch_misalign); end
`endif
    // Stale response right after reset, with nothing in flight, must be ignored.
    @(negedge clk);
    mq.delete(); req_log.delete(); pop_log.delete();
    rst_n = 1'b1; cyc = 0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    finish_cycle();
    repeat (3) cycle();
    checks++;
    if (pop_log.size() < 1 || pop_log[0].pc !== BASE || pop_log[0].data !== 32'h8000_0013) begin
      errors++;
      $display("FAIL stale_rsp: got pc=%h inst=%h want pc=%h inst=80000013",
               (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, (pop_log.size() > 0) ? pop_log[0].data : 32'hx, BASE);
    end
  endtask

  task automatic test_stream();
    do_reset(1);
    drive_mem(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== BASE) begin
      errors++; $display("FAIL first_req: got valid=%b addr=%h want 1 %h", bus.imem_req_valid, bus.imem_req_addr, BASE);
    end
    finish_cycle();
    repeat (6) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_log.size() <= k || req_log[k].cyc !== k || req_log[k].addr !== BASE + 64'(4*k)) begin
        errors++;
        $display("FAIL stream_req%0d: got cyc=%0d addr=%h want cyc=%0d addr=%h", k,
                 (req_log.size() > k) ? req_log[k].cyc : -1, (req_log.size() > k) ? req_log[k].addr : 64'hx, k, BASE + 64'(4*k));
      end
    end
    checks++; if (pop_log.size() < 1 || pop_log[0].cyc !== 2 || pop_log[0].pc !== BASE || pop_log[0].data !== 32'h8000_0013) begin
      errors++; $display("FAIL stream_pop0: got cyc=%0d pc=%h want cyc=2 pc=%h", (pop_log.size() > 0) ? pop_log[0].cyc : -1, (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, BASE);
    end
    checks++; if (pop_log.size() < 2 || pop_log[1].cyc !== 3 || pop_log[1].pc !== BASE + 64'h4 || pop_log[1].data !== 32'h8000_0017) begin
      errors++; $display("FAIL stream_pop1: got cyc=%0d pc=%h want cyc=3 pc=%h", (pop_log.size() > 1) ? pop_log[1].cyc : -1, (pop_log.size() > 1) ? pop_log[1].pc : 64'hx, BASE + 64'h4);
    end
  endtask

  task automatic test_decode_stall();
    logic [31:0] exp_d [4];
    exp_d = '{32'h8000_0013, 32'h8000_0017, 32'h8000_001B, 32'h8000_001F};
    do_reset(1);
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_mem(); #1;
      if (i >= 2) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== BASE || bus.inst !== 32'h8000_0013) begin
          errors++; $display("FAIL stall_head c%0d: got v=%b pc=%h inst=%h want 1 %h 80000013", i, bus.inst_valid, bus.inst_pc, bus.inst, BASE);
        end
      end
      finish_cycle();
    end
    checks++; if (req_log.size() > 2) begin errors++; $display("FAIL stall_reqs: got %0d requests want <=2", req_log.size()); end
    bus.inst_ready = 1'b1;
    repeat (8) cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pop_log.size() <= k || pop_log[k].cyc !== 10 + k || pop_log[k].pc !== BASE + 64'(4*k) || pop_log[k].data !== exp_d[k]) begin
        errors++;
        $display("FAIL drain%0d: got cyc=%0d pc=%h inst=%h want cyc=%0d pc=%h inst=%h", k,
                 (pop_log.size() > k) ? pop_log[k].cyc : -1, (pop_log.size() > k) ? pop_log[k].pc : 64'hx,
                 (pop_log.size() > k) ? pop_log[k].data : 32'hx, 10 + k, BASE + 64'(4*k), exp_d[k]);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3);
    repeat (2) cycle();
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h1000;
    cycle();
    redirect_valid = 1'b0;
    repeat (10) cycle();
    checks++; if (req_log.size() < 3 || req_log[2].cyc !== 4 || req_log[2].addr !== BASE + 64'h1000) begin
      errors++; $display("FAIL redir_req: got cyc=%0d addr=%h want cyc=4 addr=%h", (req_log.size() > 2) ? req_log[2].cyc : -1, (req_log.size() > 2) ? req_log[2].addr : 64'hx, BASE + 64'h1000);
    end
    checks++; if (pop_log.size() < 1 || pop_log[0].cyc !== 8 || pop_log[0].pc !== BASE + 64'h1000 || pop_log[0].data !== 32'h8000_1013) begin
      errors++; $display("FAIL redir_pop: got cyc=%0d pc=%h want cyc=8 pc=%h", (pop_log.size() > 0) ? pop_log[0].cyc : -1, (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, BASE + 64'h1000);
    end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset(2);
    repeat (2) cycle();
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h2000;
    drive_mem(); #1;
    checks++; if (bus.imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_present: got %b want 1", bus.imem_rsp_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_no_req: got %b want 0", bus.imem_req_valid); end
    finish_cycle();
    redirect_valid = 1'b0;
    repeat (8) cycle();
    checks++; if (req_log.size() < 3 || req_log[2].cyc !== 3 || req_log[2].addr !== BASE + 64'h2000) begin
      errors++; $display("FAIL rr_req: got cyc=%0d addr=%h want cyc=3 addr=%h", (req_log.size() > 2) ? req_log[2].cyc : -1, (req_log.size() > 2) ? req_log[2].addr : 64'hx, BASE + 64'h2000);
    end
    checks++; if (pop_log.size() < 1 || pop_log[0].cyc !== 6 || pop_log[0].pc !== BASE + 64'h2000 || pop_log[0].data !== 32'h8000_2013) begin
      errors++; $display("FAIL rr_pop: got cyc=%0d pc=%h want cyc=6 pc=%h", (pop_log.size() > 0) ? pop_log[0].cyc : -1, (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, BASE + 64'h2000);
    end
  endtask

  task automatic test_req_stall();
    do_reset(1);
    cycle();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_mem(); #1;
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== BASE + 64'h4) begin
        errors++; $display("FAIL req_hold c%0d: got v=%b addr=%h want 1 %h", i, bus.imem_req_valid, bus.imem_req_addr, BASE + 64'h4);
      end
      finish_cycle();
    end
    bus.imem_req_ready = 1'b1;
    repeat (3) cycle();
    checks++; if (req_log.size() < 2 || req_log[1].cyc !== 5 || req_log[1].addr !== BASE + 64'h4) begin
      errors++; $display("FAIL req_resume: got cyc=%0d addr=%h want cyc=5 addr=%h", (req_log.size() > 1) ? req_log[1].cyc : -1, (req_log.size() > 1) ? req_log[1].addr : 64'hx, BASE + 64'h4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(3);
    repeat (2) cycle();
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h3000;
    cycle();
    redirect_pc = BASE + 64'h4000;
    cycle();
    redirect_valid = 1'b0;
    repeat (8) cycle();
    checks++; if (req_log.size() < 3 || req_log[2].cyc !== 4 || req_log[2].addr !== BASE + 64'h4000) begin
      errors++; $display("FAIL b2b_req: got cyc=%0d addr=%h want cyc=4 addr=%h", (req_log.size() > 2) ? req_log[2].cyc : -1, (req_log.size() > 2) ? req_log[2].addr : 64'hx, BASE + 64'h4000);
    end
    checks++; if (pop_log.size() < 1 || pop_log[0].pc !== BASE + 64'h4000 || pop_log[0].data !== 32'h8000_4013) begin
      errors++; $display("FAIL b2b_pop: got pc=%h want %h", (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, BASE + 64'h4000);
    end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset(1);
    repeat (2) cycle();
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h2;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_mem(); #1;
      checks++;
      if (fetch_misalign !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
        errors++; $display("FAIL misalign c%0d: got trap=%b req=%b iv=%b want 1 0 0", i, fetch_misalign, bus.imem_req_valid, bus.inst_valid);
      end
      finish_cycle();
    end
  endtask
`else
  task automatic test_align_force();
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h5002;
    cycle();
    redirect_valid = 1'b0;
    repeat (4) cycle();
    checks++; if (req_log.size() < 1 || req_log[0].cyc !== 1 || req_log[0].addr !== BASE + 64'h5000) begin
      errors++; $display("FAIL align_req: got cyc=%0d addr=%h want cyc=1 addr=%h", (req_log.size() > 0) ? req_log[0].cyc : -1, (req_log.size() > 0) ? req_log[0].addr : 64'hx, BASE + 64'h5000);
    end
    checks++; if (pop_log.size() < 1 || pop_log[0].pc !== BASE + 64'h5000 || pop_log[0].data !== 32'h8000_5013) begin
      errors++; $display("FAIL align_pop: got pc=%h want %h", (pop_log.size() > 0) ? pop_log[0].pc : 64'hx, BASE + 64'h5000);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    cyc = 0; lat = 1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_decode_stall();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_req_stall();
    test_back_to_back();
`ifdef IF_MISALIGN_CHK_EN
    test_misalign();
`else
    test_align_force();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
